// File: rtl/fir_feeder.sv
// fir_feeder: producer side of the FIR_Filter x/h/x_en interface.
// Serially loads a coefficient bank, then streams FIFO'd samples.
module fir_feeder #(
    parameter int WL    = 8,
    parameter int TAPS  = 3,
    parameter int AW    = 5,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [WL-1:0] cfg_data,
    input  logic          load_start,
    input  logic          s_valid,
    input  logic [WL-1:0] s_data,
    output logic          s_ready,
    input  logic          adv,
    output logic          x_en,
    output logic [WL-1:0] h,
    output logic [WL-1:0] x,
    output logic          busy,
    output logic          done,
    output logic          underrun
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int IW = AW + 1;

    localparam logic [IW-1:0] LAST = IW'(TAPS - 1);
    localparam logic [IW-1:0] TOP  = IW'(TAPS);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [WL-1:0] coef [TAPS];
    logic [WL-1:0] mem  [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [CW-1:0] count;

    logic          in_load;
    logic          in_stream;
    logic          start;
    logic          flush;
    logic          push;
    logic          pop;
    logic [IW-1:0] rd_idx;
    logic [WL-1:0] hsel;

    // Handshake qualifiers; a load request pre-empts any push/pop
    always_comb begin
        in_load   = (state == LOAD);
        in_stream = (state == STREAM);
        start     = load_start && !in_load;
        flush     = in_stream && load_start;
        s_ready   = in_stream && (count < FULL);
        push      = in_stream && !load_start
                    && s_valid && s_ready;
        pop       = in_stream && !load_start
                    && adv && (count != '0);
        rd_idx    = in_load ? idx : '0;
    end

    // Coefficient read mux; entry 0 is presented on the start edge
    always_comb begin
        hsel = '0;
        for (int i = 0; i < TAPS; i++) begin
            if (rd_idx == IW'(i)) begin
                hsel = coef[i];
            end
        end
    end

    // Coefficient bank; out-of-range or mid-load writes are dropped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) begin
                coef[i] <= '0;
            end
        end else if (cfg_we && !in_load) begin
            for (int i = 0; i < TAPS; i++) begin
                if (cfg_addr == AW'(i)) begin
                    coef[i] <= cfg_data;
                end
            end
        end
    end

    // Control FSM with registered filter-side outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= '0;
            x_en     <= 1'b0;
            h        <= '0;
            x        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                state    <= LOAD;
                x_en     <= 1'b1;
                busy     <= 1'b1;
                h        <= hsel;
                x        <= '0;
                idx      <= IW'(1);
                done     <= (TAPS == 1);
                underrun <= 1'b0;
            end else begin
                case (state)
                    LOAD: begin
                        if (idx == TOP) begin
                            state <= STREAM;
                            x_en  <= 1'b0;
                            busy  <= 1'b0;
                        end else begin
                            h    <= hsel;
                            idx  <= idx + 1'b1;
                            done <= (idx == LAST);
                        end
                    end
                    STREAM: begin
                        if (adv) begin
                            if (count != '0) begin
                                x <= mem[rp];
                            end else begin
                                x        <= '0;
                                underrun <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // FIFO pointers and occupancy; load request flushes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= s_data;
        end
    end

endmodule
